hc21_int_vector: RTL and testbench

HC21_INT_VECTOR -- requirements
Module: hc21_int_vector

---
 rtl/hc21_int_vector_if.sv | 26 ++
 rtl/hc21_int_vector.sv | 133 +++++++++++++
 tb/tb_hc21_int_vector.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hc21_int_vector_if.sv
// Bus bundle for the STE interrupt vector unit: attention requests, Z80 control/data
// inputs and the vector/acknowledge/status outputs.
interface hc21_int_vector_if;
  logic [7:0] atnrq_n;
  logic       cpu_m1_n;
  logic       cpu_iorq_n;
  logic       cpu_wr_n;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_data_in;
  logic [7:0] vec_data;
  logic       vec_oe;
  logic       ack_valid;
  logic [2:0] ack_level;
  logic [7:0] spurious_cnt;
  logic       timeout_err;

  modport master (
    output atnrq_n, cpu_m1_n, cpu_iorq_n, cpu_wr_n, cpu_addr, cpu_data_in,
    input  vec_data, vec_oe, ack_valid, ack_level, spurious_cnt, timeout_err
  );

  modport slave (
    input  atnrq_n, cpu_m1_n, cpu_iorq_n, cpu_wr_n, cpu_addr, cpu_data_in,
    output vec_data, vec_oe, ack_valid, ack_level, spurious_cnt, timeout_err
  );
endinterface

// File: rtl/hc21_int_vector.sv
// Z80 mode-2 style interrupt vector generator for STE attention requests:
// answers INTA cycles with {base[7:4], level, 0} and tracks spurious/timeout events.
module hc21_int_vector #(
  parameter logic [7:0] BASE_PORT = 8'hF0,
  parameter logic [7:0] TIMEOUT   = 8'd255
) (
  input logic              sysclk,
  input logic              sysrst,
  hc21_int_vector_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    DRIVE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] atn_s1_q, atn_s2_q;
  logic [2:0] ctl_s1_q, ctl_s2_q;
  logic       m1_n_s, iorq_n_s, wr_n_s;
  logic [6:0] pending;
  logic       wr_cond, base_wr, drive_expire;
  logic       nmi_unused;
  logic [7:0] base_q, base_d;
  logic [7:0] vec_q, vec_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] spur_q, spur_d;
  logic       terr_q, terr_d;
  logic       wr_prev_q, wr_prev_d;

  // Lowest pending index wins; bit i of pend is level i+1.
  function automatic logic [2:0] prio_level(input logic [6:0] pend);
    prio_level = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (pend[i]) prio_level = 3'(i + 1);
    end
  endfunction

  always_ff @(posedge sysclk or posedge sysrst) begin
    if (sysrst) begin
      atn_s1_q <= 8'hFF;
      atn_s2_q <= 8'hFF;
      ctl_s1_q <= 3'b111;
      ctl_s2_q <= 3'b111;
    end else begin
      atn_s1_q <= bus.atnrq_n;
      atn_s2_q <= atn_s1_q;
      ctl_s1_q <= {bus.cpu_m1_n, bus.cpu_iorq_n, bus.cpu_wr_n};
      ctl_s2_q <= ctl_s1_q;
    end
  end

  assign m1_n_s       = ctl_s2_q[2];
  assign iorq_n_s     = ctl_s2_q[1];
  assign wr_n_s       = ctl_s2_q[0];
  assign pending      = ~atn_s2_q[7:1];
  assign nmi_unused   = atn_s2_q[0];
  // Address/data are stable across the whole I/O cycle, so they are used unsynchronised.
  assign wr_cond      = m1_n_s & ~iorq_n_s & ~wr_n_s & (bus.cpu_addr == BASE_PORT);
  assign base_wr      = wr_cond & ~wr_prev_q;
  assign drive_expire = (cnt_q == TIMEOUT - 8'd1);

  always_ff @(posedge sysclk or posedge sysrst) begin
    if (sysrst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!m1_n_s && !iorq_n_s) state_d = LATCH;
      LATCH:   state_d = DRIVE;
      DRIVE:   if (iorq_n_s || drive_expire) state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    base_d    = base_wr ? bus.cpu_data_in : base_q;
    wr_prev_d = wr_cond;
    cnt_d     = (state_q == DRIVE) ? cnt_q + 8'd1 : 8'd0;
    vec_d     = vec_q;
    spur_d    = spur_q;
    if (state_q == LATCH) begin
      vec_d = {base_q[7:4], prio_level(pending), 1'b0};
      if (pending == 7'd0 && spur_q != 8'hFF) spur_d = spur_q + 8'd1;
    end
    // A timeout on the same edge as a base write leaves the flag set.
    terr_d = base_wr ? 1'b0 : terr_q;
    if (state_q == DRIVE && !iorq_n_s && drive_expire) terr_d = 1'b1;
  end

  always_ff @(posedge sysclk or posedge sysrst) begin
    if (sysrst) begin
      base_q    <= 8'h00;
      vec_q     <= 8'h00;
      cnt_q     <= 8'h00;
      spur_q    <= 8'h00;
      terr_q    <= 1'b0;
      wr_prev_q <= 1'b0;
    end else begin
      base_q    <= base_d;
      vec_q     <= vec_d;
      cnt_q     <= cnt_d;
      spur_q    <= spur_d;
      terr_q    <= terr_d;
      wr_prev_q <= wr_prev_d;
    end
  end

  // Outputs decode straight from state so an async reset drops vec_oe immediately.
  always_comb begin
    bus.vec_oe    = 1'b0;
    bus.vec_data  = 8'h00;
    bus.ack_valid = 1'b0;
    bus.ack_level = 3'd0;
    if (state_q == DRIVE) begin
      bus.vec_oe   = 1'b1;
      bus.vec_data = vec_q;
      if (cnt_q == 8'd0) begin
        bus.ack_valid = 1'b1;
        bus.ack_level = vec_q[3:1];
      end
    end
  end

  assign bus.spurious_cnt = spur_q;
  assign bus.timeout_err  = terr_q;

endmodule

// File: tb/tb_hc21_int_vector.sv
// Randomised and directed bench for hc21_int_vector against an interval-based
// reference model of INTA handling, plus literal latency/value checks.
module tb_hc21_int_vector;
  localparam logic [7:0] BASE_PORT = 8'hF0;
  localparam int         TMO       = 255;

  logic sysclk = 1'b0;
  logic sysrst = 1'b1;

  hc21_int_vector_if bus();

  hc21_int_vector #(.BASE_PORT(BASE_PORT), .TIMEOUT(8'(TMO))) dut (
    .sysclk(sysclk),
    .sysrst(sysrst),
    .bus   (bus)
  );

  always #5 sysclk = ~sysclk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s got=%0h want=%0h", name, got, want);
  endtask

  // Reference model: pins reach the logic two edges late; an INTA seen at edge t
  // drives from edge t+1 until iorq release or TIMEOUT drive cycles, then the unit
  // is blind to INTA for two more edges.
  logic [7:0] h1_atn = 8'hFF, h2_atn = 8'hFF;
  logic [2:0] h1_ctl = 3'b111, h2_ctl = 3'b111;
  int         ecount = 0, inta_at = -10, free_at = 0, m_spur = 0;
  bit         active = 0, m_terr = 0, prev_wr = 0;
  logic [7:0] m_base = 8'h00, m_vec = 8'h00;

  always @(posedge sysclk or posedge sysrst) begin : model
    logic [7:0] s_atn;
    logic [2:0] s_ctl;
    logic [6:0] pend;
    logic [2:0] lvl;
    bit         cond, bw, t_set;
    if (sysrst) begin
      h1_atn = 8'hFF; h2_atn = 8'hFF; h1_ctl = 3'b111; h2_ctl = 3'b111;
      ecount = 0; inta_at = -10; free_at = 0; m_spur = 0;
      active = 0; m_terr = 0; prev_wr = 0; m_base = 8'h00; m_vec = 8'h00;
    end else begin
      s_atn = h2_atn; s_ctl = h2_ctl;
      h2_atn = h1_atn; h2_ctl = h1_ctl;
      h1_atn = bus.atnrq_n; h1_ctl = {bus.cpu_m1_n, bus.cpu_iorq_n, bus.cpu_wr_n};
      ecount++;
      cond = (s_ctl == 3'b100) && (bus.cpu_addr == BASE_PORT);
      bw = cond && !prev_wr;
      prev_wr = cond;
      t_set = 0;
      if (!active) begin
        if (ecount >= free_at && s_ctl[2] == 1'b0 && s_ctl[1] == 1'b0) begin
          active = 1; inta_at = ecount;
        end
      end else if (ecount == inta_at + 1) begin
        pend = ~s_atn[7:1];
        lvl = 3'd0;
        for (int i = 7; i >= 1; i--) if (pend[i-1]) lvl = 3'(i);
        m_vec = {m_base[7:4], lvl, 1'b0};
        if (pend == 7'd0 && m_spur < 255) m_spur++;
      end else if (s_ctl[1]) begin
        active = 0; free_at = ecount + 2;
      end else if (ecount - (inta_at + 1) == TMO) begin
        active = 0; free_at = ecount + 2; t_set = 1;
      end
      if (bw) begin m_base = bus.cpu_data_in; m_terr = 0; end
      if (t_set) m_terr = 1;
    end
  end

  always @(negedge sysclk) begin : compare
    bit e_oe, e_ack;
    e_oe  = active && (ecount >= inta_at + 1);
    e_ack = active && (ecount == inta_at + 1);
    chk("vec_oe", bus.vec_oe, e_oe);
    chk("vec_data", bus.vec_data, e_oe ? m_vec : 8'h00);
    chk("ack_valid", bus.ack_valid, e_ack);
    chk("ack_level", bus.ack_level, e_ack ? m_vec[3:1] : 3'd0);
    chk("spurious_cnt", bus.spurious_cnt, m_spur);
    chk("timeout_err", bus.timeout_err, m_terr);
  end

  task automatic step();
    @(posedge sysclk); #1;
  endtask

  task automatic idle_pins();
    bus.cpu_m1_n = 1'b1; bus.cpu_iorq_n = 1'b1; bus.cpu_wr_n = 1'b1;
  endtask

  task automatic io_write(input logic [7:0] addr, input logic [7:0] data);
    bus.cpu_m1_n = 1'b1; bus.cpu_iorq_n = 1'b0; bus.cpu_wr_n = 1'b0;
    bus.cpu_addr = addr; bus.cpu_data_in = data;
    repeat (4) step();
    idle_pins();
    repeat (4) step();
  endtask

  task automatic inta(input logic [7:0] atn, input int hold);
    bus.atnrq_n = atn;
    bus.cpu_m1_n = 1'b0; bus.cpu_iorq_n = 1'b0;
    repeat (hold) step();
    idle_pins();
    repeat (5) step();
  endtask

  task automatic inta_chk(input string nm, input logic [7:0] atn,
                          input logic [7:0] exp_vec, input logic [2:0] exp_lvl);
    bus.atnrq_n = atn;
    bus.cpu_m1_n = 1'b0; bus.cpu_iorq_n = 1'b0;
    repeat (4) step();
    chk({nm, "_oe"}, bus.vec_oe, 1'b1);
    chk({nm, "_vec"}, bus.vec_data, exp_vec);
    chk({nm, "_ack"}, bus.ack_valid, 1'b1);
    chk({nm, "_lvl"}, bus.ack_level, exp_lvl);
    step();
    idle_pins();
    repeat (5) step();
  endtask

  initial begin
    bus.atnrq_n = 8'hFF; bus.cpu_addr = 8'h00; bus.cpu_data_in = 8'h00;
    idle_pins();
    repeat (3) step();
    chk("rst_oe", bus.vec_oe, 1'b0);
    chk("rst_spur", bus.spurious_cnt, 8'h00);
    sysrst = 1'b0;
    repeat (3) step();

    // Basic vector and latency
    io_write(BASE_PORT, 8'hA0);
    bus.atnrq_n = 8'b1111_0111;
    step();
    bus.cpu_m1_n = 1'b0; bus.cpu_iorq_n = 1'b0;
    repeat (3) step();
    chk("lat_edge3_oe", bus.vec_oe, 1'b0);
    step();
    chk("lat_edge4_oe", bus.vec_oe, 1'b1);
    chk("basic_vec", bus.vec_data, 8'hA6);
    chk("basic_ack", bus.ack_valid, 1'b1);
    chk("basic_lvl", bus.ack_level, 3'd3);
    step();
    chk("ack_pulse_end", bus.ack_valid, 1'b0);
    idle_pins();
    repeat (2) step();
    chk("rel_edge2_oe", bus.vec_oe, 1'b1);
    step();
    chk("rel_edge3_oe", bus.vec_oe, 1'b0);
    repeat (3) step();

    inta_chk("prio", 8'b0111_1101, 8'hA2, 3'd1);

    // Requests change mid-DRIVE; snapshot must hold
    bus.atnrq_n = 8'b1111_0111;
    bus.cpu_m1_n = 1'b0; bus.cpu_iorq_n = 1'b0;
    repeat (4) step();
    bus.atnrq_n = 8'h00;
    repeat (6) step();
    chk("snap_vec", bus.vec_data, 8'hA6);
    // Base write accepted while still in DRIVE
    bus.cpu_m1_n = 1'b1; bus.cpu_wr_n = 1'b0;
    bus.cpu_addr = BASE_PORT; bus.cpu_data_in = 8'h50;
    repeat (4) step();
    chk("snap_vec2", bus.vec_data, 8'hA6);
    idle_pins();
    repeat (5) step();
    inta_chk("drvwr", 8'b1111_0111, 8'h56, 3'd3);

    // Spurious acknowledges
    io_write(BASE_PORT, 8'hA0);
    for (int i = 0; i < 3; i++) inta_chk("spur", 8'hFF, 8'hA0, 3'd0);
    chk("spur3", bus.spurious_cnt, 8'd3);
    for (int i = 0; i < 258; i++) inta(8'hFF, 2);
    chk("spur_sat", bus.spurious_cnt, 8'hFF);

    // DRIVE timeout
    bus.atnrq_n = 8'b1111_0111;
    bus.cpu_m1_n = 1'b0; bus.cpu_iorq_n = 1'b0;
    repeat (258) step();
    chk("tmo_edge258_oe", bus.vec_oe, 1'b1);
    step();
    chk("tmo_edge259_oe", bus.vec_oe, 1'b0);
    chk("tmo_err", bus.timeout_err, 1'b1);
    repeat (41) step();
    idle_pins();
    repeat (10) step();
    chk("tmo_sticky", bus.timeout_err, 1'b1);
    io_write(BASE_PORT, 8'hA0);
    chk("tmo_clear", bus.timeout_err, 1'b0);

    // Asynchronous reset in DRIVE
    bus.cpu_m1_n = 1'b0; bus.cpu_iorq_n = 1'b0;
    repeat (6) step();
    chk("arst_pre_oe", bus.vec_oe, 1'b1);
    #2 sysrst = 1'b1;
    #1;
    chk("arst_oe", bus.vec_oe, 1'b0);
    chk("arst_vec", bus.vec_data, 8'h00);
    chk("arst_ack", bus.ack_valid, 1'b0);
    chk("arst_lvl", bus.ack_level, 3'd0);
    chk("arst_spur", bus.spurious_cnt, 8'h00);
    chk("arst_terr", bus.timeout_err, 1'b0);
    idle_pins();
    repeat (2) step();
    sysrst = 1'b0;
    repeat (3) step();
    inta_chk("post_rst", 8'b1111_0111, 8'h06, 3'd3);

    // Randomised traffic
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0: io_write(($urandom_range(0, 1) != 0) ? BASE_PORT : 8'($urandom), 8'($urandom));
        1: begin
          bus.atnrq_n = 8'($urandom);
          bus.cpu_m1_n = 1'b0; bus.cpu_iorq_n = 1'b0;
          repeat ($urandom_range(1, 6)) step();
          if ($urandom_range(0, 1) != 0) bus.atnrq_n = 8'($urandom);
          repeat ($urandom_range(1, 6)) step();
          idle_pins();
          repeat (5) step();
        end
        2: begin
          bus.atnrq_n = 8'($urandom);
          repeat ($urandom_range(1, 5)) step();
        end
        default: begin
          bus.cpu_m1_n = 1'b0;
          repeat ($urandom_range(1, 4)) step();
          idle_pins();
          repeat (2) step();
        end
      endcase
    end
    repeat (5) step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
